// File: rtl/if_stage_pkg.sv
// Shared widths, reset PC and bus field layouts for the fetch stage and its neighbours.
package if_stage_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h1C00_0000;
  localparam int          BR_BUS_WD        = 33;
  localparam int          FS_TO_DS_BUS_WD  = 65;

  // Branch redirect from ID: {br_taken, br_target}
  typedef struct packed {
    logic        br_taken;
    logic [31:0] br_target;
  } br_bus_t;

  // Fetch-to-decode payload: {fs_adef, fs_pc, fs_inst}
  typedef struct packed {
    logic        adef;
    logic [31:0] pc;
    logic [31:0] inst;
  } fs_to_ds_t;

endpackage

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues inst SRAM reads, buffers the
// fetched word while ID stalls and drops wrong-path words on a redirect.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ds_allowin,
  input  logic [BR_BUS_WD-1:0]       br_bus,
  output logic                       fs_to_ds_valid,
  output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
  output logic                       inst_sram_en,
  output logic                       inst_sram_we,
  output logic [31:0]                inst_sram_addr,
  output logic [31:0]                inst_sram_wdata,
  input  logic [31:0]                inst_sram_rdata
);

  br_bus_t     br;
  fs_to_ds_t   fs_out;

  logic        fs_valid;
  logic [31:0] fs_pc;
  logic [31:0] inst_buf;
  logic        inst_buf_valid;

  logic        to_fs_valid;
  logic        fs_allowin;
  logic        fetch_go;
  logic        buf_capture;
  logic [31:0] nextpc;
  logic        fs_adef;
  logic [31:0] fs_inst;

  assign br = br_bus_t'(br_bus);

  // Pre-IF: next PC selection and fetch request
  always_comb begin
    to_fs_valid = ~reset;
    nextpc      = br.br_taken ? br.br_target : fs_pc + 32'd4;
    fs_allowin  = ~fs_valid | ds_allowin | br.br_taken;
    fetch_go    = to_fs_valid & fs_allowin;
    buf_capture = fs_valid & ~ds_allowin & ~br.br_taken & ~inst_buf_valid;
  end

  assign inst_sram_en    = fetch_go;
  assign inst_sram_we    = 1'b0;
  assign inst_sram_addr  = {nextpc[31:2], 2'b00};
  assign inst_sram_wdata = 32'h0;

  // IF stage PC/valid and stall buffer; a fetch always invalidates the buffer
  always_ff @(posedge clk) begin
    if (reset) begin
      fs_valid       <= 1'b0;
      fs_pc          <= RESET_PC - 32'd4;
      inst_buf       <= 32'h0;
      inst_buf_valid <= 1'b0;
    end else if (fetch_go) begin
      fs_valid       <= 1'b1;
      fs_pc          <= nextpc;
      inst_buf_valid <= 1'b0;
    end else if (buf_capture) begin
      inst_buf       <= inst_sram_rdata;
      inst_buf_valid <= 1'b1;
    end
  end

  // Output payload; a misaligned PC is passed through with a zeroed word so ID raises ADEF
  always_comb begin
    fs_adef        = fs_pc[1:0] != 2'b00;
    fs_inst        = fs_adef ? 32'h0 : (inst_buf_valid ? inst_buf : inst_sram_rdata);
    fs_out.adef    = fs_adef;
    fs_out.pc      = fs_pc;
    fs_out.inst    = fs_inst;
    fs_to_ds_valid = fs_valid & ~br.br_taken;
  end

  assign fs_to_ds_bus = fs_out;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a 1-cycle inst SRAM model that returns
// addr ^ 32'hA5A5_0000 when read and a scramble word when idle.
module tb_if_stage;

  logic        clk;
  logic        reset;
  logic        ds_allowin;
  logic [32:0] br_bus;
  logic        fs_to_ds_valid;
  logic [64:0] fs_to_ds_bus;
  logic        inst_sram_en;
  logic        inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] KEY   = 32'hA5A5_0000;
  localparam logic [31:0] JUNK  = 32'hDEAD_BEEF;

  if_stage dut (
    .clk             (clk),
    .reset           (reset),
    .ds_allowin      (ds_allowin),
    .br_bus          (br_bus),
    .fs_to_ds_valid  (fs_to_ds_valid),
    .fs_to_ds_bus    (fs_to_ds_bus),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_we    (inst_sram_we),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    inst_sram_rdata <= inst_sram_en ? (inst_sram_addr ^ KEY) : JUNK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bus(input string tag, input logic v, input logic adef,
                         input logic [31:0] pc, input logic [31:0] inst);
    chk({tag, "_valid"}, {31'b0, fs_to_ds_valid}, {31'b0, v});
    chk({tag, "_adef"},  {31'b0, fs_to_ds_bus[64]}, {31'b0, adef});
    chk({tag, "_pc"},    fs_to_ds_bus[63:32], pc);
    chk({tag, "_inst"},  fs_to_ds_bus[31:0], inst);
  endtask

  task automatic chk_req(input string tag, input logic en, input logic [31:0] addr);
    chk({tag, "_en"}, {31'b0, inst_sram_en}, {31'b0, en});
    if (en) chk({tag, "_addr"}, inst_sram_addr, addr);
  endtask

  initial begin
    reset      = 1'b1;
    ds_allowin = 1'b1;
    br_bus     = 33'h0;

    // 1. reset then straight-line fetch
    tick(); tick(); tick();
    #1;
    chk("rst_en", {31'b0, inst_sram_en}, 32'h0);
    chk("rst_valid", {31'b0, fs_to_ds_valid}, 32'h0);
    chk("we_tied", {31'b0, inst_sram_we}, 32'h0);
    chk("wdata_tied", inst_sram_wdata, 32'h0);
    reset = 1'b0;
    #1;
    chk_req("c0", 1'b1, 32'h1C00_0000);
    tick(); #1;
    chk_bus("c1", 1'b1, 1'b0, 32'h1C00_0000, 32'hB9A5_0000);
    chk_req("c1", 1'b1, 32'h1C00_0004);
    tick(); #1;
    chk_bus("c2", 1'b1, 1'b0, 32'h1C00_0004, 32'hB9A5_0004);
    chk_req("c2", 1'b1, 32'h1C00_0008);

    // 2. three-cycle stall at 1C000008; word held through scrambled SRAM output
    tick();
    ds_allowin = 1'b0;
    #1;
    chk_bus("st0", 1'b1, 1'b0, 32'h1C00_0008, 32'hB9A5_0008);
    chk_req("st0", 1'b0, 32'h0);
    tick(); #1;
    chk_bus("st1", 1'b1, 1'b0, 32'h1C00_0008, 32'hB9A5_0008);
    chk_req("st1", 1'b0, 32'h0);
    tick(); #1;
    chk_bus("st2", 1'b1, 1'b0, 32'h1C00_0008, 32'hB9A5_0008);
    chk_req("st2", 1'b0, 32'h0);
    tick();
    ds_allowin = 1'b1;
    #1;
    chk_bus("rel", 1'b1, 1'b0, 32'h1C00_0008, 32'hB9A5_0008);
    chk_req("rel", 1'b1, 32'h1C00_000C);

    // 3. branch while a live word sits in IF
    tick();
    br_bus = {1'b1, 32'h1C00_0100};
    #1;
    chk("br_valid", {31'b0, fs_to_ds_valid}, 32'h0);
    chk_req("br", 1'b1, 32'h1C00_0100);
    tick();
    br_bus = 33'h0;
    #1;
    chk_bus("tgt", 1'b1, 1'b0, 32'h1C00_0100, 32'hB9A5_0100);
    chk_req("tgt", 1'b1, 32'h1C00_0104);

    // 4. branch during stall with full buffer
    tick();
    ds_allowin = 1'b0;
    #1;
    chk_req("s4a", 1'b0, 32'h0);
    tick(); #1;
    chk_bus("s4b", 1'b1, 1'b0, 32'h1C00_0104, 32'hB9A5_0104);
    br_bus = {1'b1, 32'h1C00_0200};
    #1;
    chk("s4br_valid", {31'b0, fs_to_ds_valid}, 32'h0);
    chk_req("s4br", 1'b1, 32'h1C00_0200);
    tick();
    br_bus     = 33'h0;
    ds_allowin = 1'b1;
    #1;
    chk_bus("s4t", 1'b1, 1'b0, 32'h1C00_0200, 32'hB9A5_0200);

    // 5. misaligned branch target
    tick();
    br_bus = {1'b1, 32'h1C00_0102};
    #1;
    chk_req("ad0", 1'b1, 32'h1C00_0100);
    tick();
    br_bus = 33'h0;
    #1;
    chk_bus("ad1", 1'b1, 1'b1, 32'h1C00_0102, 32'h0);
    chk_req("ad1", 1'b1, 32'h1C00_0104);
    tick(); #1;
    chk_bus("ad2", 1'b1, 1'b1, 32'h1C00_0106, 32'h0);

    // 6. reset while stalled with full buffer
    br_bus = {1'b1, 32'h1C00_0300};
    tick();
    br_bus     = 33'h0;
    ds_allowin = 1'b0;
    #1;
    chk_bus("r6a", 1'b1, 1'b0, 32'h1C00_0300, 32'hB9A5_0300);
    tick(); #1;
    chk_bus("r6b", 1'b1, 1'b0, 32'h1C00_0300, 32'hB9A5_0300);
    reset = 1'b1;
    #1;
    chk_req("r6c", 1'b0, 32'h0);
    tick(); #1;
    chk("r6d_valid", {31'b0, fs_to_ds_valid}, 32'h0);
    chk_req("r6d", 1'b0, 32'h0);
    reset      = 1'b0;
    ds_allowin = 1'b1;
    #1;
    chk_req("r6e", 1'b1, 32'h1C00_0000);
    tick(); #1;
    chk_bus("r6f", 1'b1, 1'b0, 32'h1C00_0000, 32'hB9A5_0000);

    // PC wrap
    br_bus = {1'b1, 32'hFFFF_FFFC};
    tick();
    br_bus = 33'h0;
    #1;
    chk_bus("wr0", 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h5A5A_FFFC);
    chk_req("wr0", 1'b1, 32'h0000_0000);
    tick(); #1;
    chk_bus("wr1", 1'b1, 1'b0, 32'h0000_0000, 32'hA5A5_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
